// File: rtl/memstage_pkg.sv
// rtl/memstage_pkg.sv - bexkat1 memory-stage definitions
// Instruction type codes, access-size and FSM state enums, alignment exception code.
package memstage_pkg;

  localparam logic [3:0] T_STORE   = 4'h6;
  localparam logic [3:0] T_LOAD    = 4'h7;
  localparam logic [7:0] EXC_ALIGN = 8'h02;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } memstate_t;

  // Encoding 3 is not a legal size; it behaves as a byte access.
  function automatic mem_size_t decode_size(input logic [1:0] f);
    case (f)
      2'd0:    return SZ_WORD;
      2'd1:    return SZ_HALF;
      default: return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/memstage_memlane.sv
// rtl/memstage_memlane.sv - big-endian byte-lane steering for one bus word
// Ports:
//   i_size   : ir size field (0 word, 1 half, 2/3 byte)
//   i_adr_lo : byte address bits [1:0]
//   i_wdata  : store data, right-justified
//   i_rdata  : raw bus read word
//   o_sel    : byte-lane enables (bit 3 = bus bits [31:24] = offset 0)
//   o_wdata  : store data replicated into every lane
//   o_rdata  : load data right-justified and zero-extended
module memstage_memlane
  import memstage_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_adr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  mem_size_t   w_size;
  logic [31:0] w_byte_shift;

  assign w_size = decode_size(i_size);
  // Offset 0 lives in the top lane, so shift right by (3 - offset) bytes.
  assign w_byte_shift = i_rdata >> {~i_adr_lo, 3'b000};

  always_comb begin
    o_sel   = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (w_size)
      SZ_BYTE: begin
        o_sel   = 4'b1000 >> i_adr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h0, w_byte_shift[7:0]};
      end
      SZ_HALF: begin
        o_sel   = 4'b1100 >> {i_adr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0, (i_adr_lo[1] ? i_rdata[15:0] : i_rdata[31:16])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// rtl/memstage.sv - bexkat1 memory-access stage between execute and writeback
// Optional feature: define MEMSTAGE_ALIGN_CHECK_EN to trap misaligned word/half accesses.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   ir_i, pc_i, ccr_i, reg_write_i, result_i, store_data_i, halt_i : from execute
//   stall_i / stall_o       : downstream stall in, stall to execute out
//   halt_o, ir_o, pc_o, ccr_o, reg_write_o, result_o, exc_o : registered, to writeback
//   bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
//   bus_dat_i, bus_ack_i    : single-transfer bus master
module memstage
  import memstage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  ccr_i,
  input  logic [1:0]  reg_write_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic        stall_o,
  output logic        halt_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [2:0]  ccr_o,
  output logic [1:0]  reg_write_o,
  output logic [31:0] result_o,
  output logic        exc_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  memstate_t   r_state, w_state_nxt;
  logic [63:0] r_ir;
  logic [31:0] r_pc, r_result, r_adr, r_dat, r_rdata;
  logic [2:0]  r_ccr;
  logic [1:0]  r_reg_write;
  logic [3:0]  r_sel;
  logic        r_halt, r_cyc, r_we;

  logic        w_is_load, w_is_store, w_is_mem, w_misalign;
  logic        w_launch, w_complete, w_load_out, w_bubble;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_lane_rdata, w_out_result;
  logic [1:0]  w_out_rw;

  assign w_is_load  = (ir_i[31:28] == T_LOAD);
  assign w_is_store = (ir_i[31:28] == T_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem &
      (((decode_size(ir_i[25:24]) == SZ_WORD) && (result_i[1:0] != 2'b00)) ||
       ((decode_size(ir_i[25:24]) == SZ_HALF) && result_i[0]));
`else
  assign w_misalign = 1'b0;
`endif

  // Execute holds its outputs while stalled, so in S_DONE the lane logic can
  // still be keyed off the live instruction and address.
  memstage_memlane u_lane (
    .i_size   (ir_i[25:24]),
    .i_adr_lo (result_i[1:0]),
    .i_wdata  (store_data_i),
    .i_rdata  (r_rdata),
    .o_sel    (w_sel),
    .o_wdata  (w_wdata),
    .o_rdata  (w_lane_rdata)
  );

  // Reset forces stall_o low even if a memory op is sitting at the input.
  assign stall_o = rst_i & (stall_i | (w_is_mem & (r_state != S_DONE)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    w_load_out  = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!stall_i) begin
          if (w_is_mem) begin
            w_bubble = 1'b1;
            if (w_misalign) begin
              w_state_nxt = S_DONE;
            end else begin
              w_launch    = 1'b1;
              w_state_nxt = S_BUS;
            end
          end else begin
            w_load_out = 1'b1;
          end
        end
      end
      S_BUS: begin
        // The bus transfer finishes regardless of the downstream stall.
        w_bubble = ~stall_i;
        if (bus_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall_i) begin
          w_load_out  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_result = result_i;
    w_out_rw     = reg_write_i;
    if (r_state == S_DONE) begin
      if (w_misalign) begin
        w_out_result = {24'h0, EXC_ALIGN};
        w_out_rw     = 2'b00;
      end else if (w_is_load) begin
        w_out_result = w_lane_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ir        <= '0;
      r_pc        <= '0;
      r_ccr       <= '0;
      r_reg_write <= '0;
      r_result    <= '0;
      r_halt      <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_dat       <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_load_out) begin
        r_ir        <= ir_i;
        r_pc        <= pc_i;
        r_ccr       <= ccr_i;
        r_reg_write <= w_out_rw;
        r_result    <= w_out_result;
        r_halt      <= halt_i;
      end else if (w_bubble) begin
        r_ir        <= '0;
        r_reg_write <= '0;
        r_halt      <= 1'b0;
      end
      if (w_launch) begin
        r_cyc <= 1'b1;
        r_we  <= w_is_store;
        r_adr <= {result_i[31:2], 2'b00};
        r_sel <= w_sel;
        r_dat <= w_wdata;
      end else if (w_complete) begin
        r_cyc   <= 1'b0;
        r_rdata <= bus_dat_i;
      end
    end
  end

`ifdef MEMSTAGE_ALIGN_CHECK_EN
  // One-cycle event marking the misaligned instruction as it is handed on.
  logic r_exc;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_exc <= 1'b0;
    else        r_exc <= w_load_out & (r_state == S_DONE) & w_misalign;
  end
  assign exc_o = r_exc;
`else
  assign exc_o = 1'b0;
`endif

  assign halt_o      = r_halt;
  assign ir_o        = r_ir;
  assign pc_o        = r_pc;
  assign ccr_o       = r_ccr;
  assign reg_write_o = r_reg_write;
  assign result_o    = r_result;
  assign bus_cyc_o   = r_cyc;
  assign bus_stb_o   = r_cyc;
  assign bus_we_o    = r_we;
  assign bus_adr_o   = r_adr;
  assign bus_sel_o   = r_sel;
  assign bus_dat_o   = r_dat;

endmodule

// File: tb/tb_memstage.sv
// tb/tb_memstage.sv - self-checking bench for memstage
module tb_memstage;
  import memstage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [63:0] ir_i = '0;
  logic [31:0] pc_i = '0;
  logic [2:0]  ccr_i = '0;
  logic [1:0]  reg_write_i = '0;
  logic [31:0] result_i = '0;
  logic [31:0] store_data_i = '0;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        stall_o, halt_o, exc_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o, result_o;
  logic [2:0]  ccr_o;
  logic [1:0]  reg_write_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  memstage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .ccr_i(ccr_i),
    .reg_write_i(reg_write_i), .result_i(result_i), .store_data_i(store_data_i),
    .stall_i(stall_i), .halt_i(halt_i), .stall_o(stall_o), .halt_o(halt_o),
    .ir_o(ir_o), .pc_o(pc_o), .ccr_o(ccr_o), .reg_write_o(reg_write_o),
    .result_o(result_o), .exc_o(exc_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o),
    .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Reference rules: access width in bytes, lane offset of first byte
  // (low bits below the access width ignored), big-endian lanes.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  function automatic int first_lane(input logic [1:0] sz, input logic [31:0] adr);
    return int'(adr[1:0]) & ~(nbytes(sz) - 1);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] sz, input logic [31:0] adr);
    logic [3:0] s;
    int n, off;
    n = nbytes(sz);
    off = first_lane(sz, adr);
    s = '0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) s[3-b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdat(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nbytes(sz);
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = d[8*(n-1-(b % n)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] adr,
                                           input logic [31:0] r);
    logic [31:0] v;
    int n, off;
    n = nbytes(sz);
    off = first_lane(sz, adr);
    v = '0;
    for (int i = 0; i < n; i++) v[8*(n-1-i) +: 8] = r[31-8*(off+i) -: 8];
    return v;
  endfunction

  function automatic logic [63:0] make_ir(input logic [3:0] t, input logic [1:0] sz);
    return {32'($urandom), t, 2'($urandom_range(0, 3)), sz, 24'($urandom)};
  endfunction

  task automatic drive_nop();
    ir_i = make_ir(4'h0, 2'($urandom_range(0, 3)));
    reg_write_i = 2'($urandom_range(0, 3));
    halt_i = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [1:0] rw);
    logic [3:0] t;
    logic [63:0] ir;
    logic [31:0] pc;
    logic [2:0] ccr;
    logic hlt;
    t = 4'($urandom_range(0, 15));
    if (t == T_LOAD || t == T_STORE) t = 4'h0;
    ir = make_ir(t, 2'($urandom_range(0, 3)));
    pc = $urandom;
    ccr = 3'($urandom_range(0, 7));
    hlt = 1'($urandom_range(0, 1));
    ir_i = ir; pc_i = pc; ccr_i = ccr; halt_i = hlt;
    reg_write_i = rw; result_i = res; stall_i = 1'b0;
    bus_ack_i = 1'($urandom_range(0, 1));
    #1 chk("alu_stall_o", stall_o, 1'b0);
    step();
    bus_ack_i = 1'b0;
    chk("alu_ir_o", ir_o, ir);
    chk("alu_pc_o", pc_o, pc);
    chk("alu_ccr_o", ccr_o, ccr);
    chk("alu_reg_write_o", reg_write_o, rw);
    chk("alu_result_o", result_o, res);
    chk("alu_halt_o", halt_o, hlt);
    chk("alu_cyc", bus_cyc_o, 1'b0);
    chk("alu_exc", exc_o, 1'b0);
    chk("alu_stall_after", stall_o, 1'b0);
  endtask

  task automatic mem_op(input logic is_store, input logic [1:0] sz, input logic [31:0] adr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int k);
    logic [63:0] ir;
    logic [31:0] pc, ppc;
    logic [2:0] ccr, pccr;
    logic [1:0] rw;
    logic hlt, mis;
    int n;
    n = nbytes(sz);
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    mis = (n == 4 && adr[1:0] != 2'b00) || (n == 2 && adr[0]);
`else
    mis = 1'b0;
`endif
    ppc = pc_o; pccr = ccr_o;
    ir = make_ir(is_store ? T_STORE : T_LOAD, sz);
    pc = $urandom;
    ccr = 3'($urandom_range(0, 7));
    rw = 2'($urandom_range(0, 3));
    hlt = 1'($urandom_range(0, 1));
    ir_i = ir; pc_i = pc; ccr_i = ccr; reg_write_i = rw; halt_i = hlt;
    result_i = adr; store_data_i = sdata; stall_i = 1'b0;
    #1 chk("mem_stall_c0", stall_o, 1'b1);
    step();
    chk("mem_bubble_ir", ir_o, 64'h0);
    chk("mem_bubble_rw", reg_write_o, 2'b00);
    chk("mem_bubble_halt", halt_o, 1'b0);
    chk("mem_bubble_pc_hold", pc_o, ppc);
    chk("mem_bubble_ccr_hold", ccr_o, pccr);
    if (mis) begin
      chk("mis_no_cyc", bus_cyc_o, 1'b0);
      chk("mis_stall_o", stall_o, 1'b0);
      step();
      chk("mis_ir_o", ir_o, ir);
      chk("mis_exc", exc_o, 1'b1);
      chk("mis_rw", reg_write_o, 2'b00);
      chk("mis_result", result_o, {24'h0, EXC_ALIGN});
      drive_nop();
      step();
      chk("mis_exc_pulse", exc_o, 1'b0);
    end else begin
      chk("mem_stb", bus_stb_o, 1'b1);
      chk("mem_we", bus_we_o, is_store);
      chk("mem_adr", bus_adr_o, {adr[31:2], 2'b00});
      chk("mem_sel", bus_sel_o, exp_sel(sz, adr));
      if (is_store) chk("mem_dat_o", bus_dat_o, exp_wdat(sz, sdata));
      for (int c = 1; c <= k; c++) begin
        chk("mem_cyc_held", bus_cyc_o, 1'b1);
        chk("mem_stall_held", stall_o, 1'b1);
        chk("mem_bubble_wait", ir_o, 64'h0);
        bus_ack_i = (c == k);
        bus_dat_i = (c == k) ? rdata : $urandom;
        step();
      end
      bus_ack_i = 1'b0;
      bus_dat_i = $urandom;
      chk("mem_cyc_drop", bus_cyc_o, 1'b0);
      chk("mem_stb_drop", bus_stb_o, 1'b0);
      chk("mem_stall_fall", stall_o, 1'b0);
      chk("mem_bubble_done", ir_o, 64'h0);
      step();
      drive_nop();
      chk("mem_ir_o", ir_o, ir);
      chk("mem_pc_o", pc_o, pc);
      chk("mem_ccr_o", ccr_o, ccr);
      chk("mem_rw_o", reg_write_o, rw);
      chk("mem_halt_o", halt_o, hlt);
      chk("mem_result_o", result_o, is_store ? adr : exp_load(sz, adr, rdata));
      chk("mem_exc", exc_o, 1'b0);
      #1 chk("mem_next_stall", stall_o, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] ir;
    logic [31:0] ppc, adr;
    int kind;

    #3;
    chk("rst_stall_o", stall_o, 1'b0);
    chk("rst_cyc", bus_cyc_o, 1'b0);
    chk("rst_stb", bus_stb_o, 1'b0);
    chk("rst_we", bus_we_o, 1'b0);
    chk("rst_adr", bus_adr_o, 32'h0);
    chk("rst_sel", bus_sel_o, 4'h0);
    chk("rst_dat", bus_dat_o, 32'h0);
    chk("rst_ir", ir_o, 64'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ccr", ccr_o, 3'h0);
    chk("rst_rw", reg_write_o, 2'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_halt", halt_o, 1'b0);
    chk("rst_exc", exc_o, 1'b0);
    step();
    rst_i = 1'b1;
    step();

    alu_op(32'h1234, 2'd1);
    mem_op(1'b0, 2'd2, 32'h103, 32'h0, 32'hAABBCCDD, 2);
    mem_op(1'b1, 2'd1, 32'h202, 32'h0000BEEF, 32'h0, 1);
    mem_op(1'b0, 2'd0, 32'h101, 32'h0, 32'h11223344, 1);
    mem_op(1'b0, 2'd3, 32'h001, 32'h0, 32'h55667788, 3);

    // Word load acked while downstream stalls; S_DONE must hold until release.
    ppc = pc_o;
    ir = make_ir(T_LOAD, 2'd0);
    ir_i = ir; result_i = 32'h300; reg_write_i = 2'd2; halt_i = 1'b0;
    step();
    chk("stl_cyc_c1", bus_cyc_o, 1'b1);
    step();
    stall_i = 1'b1;
    #1 chk("stl_stall_c2", stall_o, 1'b1);
    step();
    bus_ack_i = 1'b1;
    bus_dat_i = 32'hCAFEF00D;
    chk("stl_cyc_c3", bus_cyc_o, 1'b1);
    step();
    bus_ack_i = 1'b0;
    bus_dat_i = 32'h0;
    chk("stl_cyc_drop", bus_cyc_o, 1'b0);
    chk("stl_stall_c4", stall_o, 1'b1);
    chk("stl_hold_ir", ir_o, 64'h0);
    step();
    chk("stl_hold_ir_c5", ir_o, 64'h0);
    chk("stl_hold_pc_c5", pc_o, ppc);
    stall_i = 1'b0;
    #1 chk("stl_stall_release", stall_o, 1'b0);
    step();
    drive_nop();
    chk("stl_result", result_o, 32'hCAFEF00D);
    chk("stl_ir", ir_o, ir);
    chk("stl_rw", reg_write_o, 2'd2);

    // Reset in the middle of a bus cycle.
    ir_i = make_ir(T_LOAD, 2'd2);
    result_i = 32'h400;
    step();
    chk("rbus_cyc", bus_cyc_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("rbus_cyc_drop", bus_cyc_o, 1'b0);
    chk("rbus_stb_drop", bus_stb_o, 1'b0);
    chk("rbus_stall", stall_o, 1'b0);
    chk("rbus_result", result_o, 32'h0);
    drive_nop();
    step();
    rst_i = 1'b1;
    alu_op(32'h89AB_CDEF, 2'd3);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      adr = $urandom;
      if (kind == 0)
        alu_op($urandom, 2'($urandom_range(0, 3)));
      else
        mem_op(kind == 2, 2'($urandom_range(0, 3)), adr, $urandom, $urandom,
               $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
